// File: rtl/exception_unit.sv
// Exception unit: sequences exception entry (overflow, optional reserved
// instruction) and ERET return. On an event, flush is pulsed for one
// cycle, then a redirect is held until fetch accepts it.
// Optional feature: define EXC_RESERVED_INSTR_EN to add the reserved_instr
// port and the RI exception (cause 10). Without it, only overflow and
// eret are events.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no exception activity, events sampled from the ALU stage
// FLUSH    | one-cycle flush of younger instructions
// REDIRECT | redirect_valid held with a stable target until redirect_ready
module exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr_pc,
  input  logic        overflow,
  input  logic        eret,
`ifdef EXC_RESERVED_INSTR_EN
  input  logic        reserved_instr,
`endif
  input  logic        redirect_ready,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic [4:0]  cause,
  output logic        exl,
  output logic        busy
);

  localparam logic [4:0] CAUSE_OV = 5'd12;
  localparam logic [4:0] CAUSE_RI = 5'd10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t state, state_next;
  logic   ret_pending;
  logic   ri_hit;
  logic   ev_ov, ev_ri, ev_exc, ev_ret;
  logic   accept;

`ifdef EXC_RESERVED_INSTR_EN
  assign ri_hit = reserved_instr;
`else
  assign ri_hit = 1'b0;
`endif

  // Event decode: only in IDLE with a real instruction; overflow > RI > eret
  always_comb begin
    ev_ov  = (state == S_IDLE) && instr_valid && overflow;
    ev_ri  = (state == S_IDLE) && instr_valid && !overflow && ri_hit;
    ev_exc = ev_ov || ev_ri;
    ev_ret = (state == S_IDLE) && instr_valid && !overflow && !ri_hit && eret && exl;
    accept = (state == S_REDIRECT) && redirect_ready;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (ev_exc || ev_ret) state_next = S_FLUSH;
      S_FLUSH:    state_next = S_REDIRECT;
      S_REDIRECT: if (redirect_ready) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; redirect target chosen by the pending kind
  always_comb begin
    flush          = (state == S_FLUSH);
    redirect_valid = (state == S_REDIRECT);
    busy           = (state != S_IDLE);
    redirect_pc    = 32'h0;
    if (state == S_REDIRECT) redirect_pc = ret_pending ? epc : EXC_VECTOR;
  end

  // Architectural registers: epc only captured on first-level entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      epc         <= 32'h0;
      cause       <= 5'd0;
      exl         <= 1'b0;
      ret_pending <= 1'b0;
    end else begin
      if (ev_exc) begin
        cause       <= ev_ov ? CAUSE_OV : CAUSE_RI;
        exl         <= 1'b1;
        ret_pending <= 1'b0;
        if (!exl) epc <= instr_pc;
      end else if (ev_ret) begin
        ret_pending <= 1'b1;
      end else if (accept && ret_pending) begin
        exl         <= 1'b0;
        ret_pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h80000180, meaning the handler address loaded into redirect_pc on exception.
REQ-002 SHALL have port clock  in  1  the single clock, rising-edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port instr_valid  in  1  the ALU-stage instruction is real, not a bubble.
REQ-005 SHALL have port instr_pc  in  32  PC of the ALU-stage instruction.
REQ-006 SHALL have port overflow  in  1  signed add/sub overflow from the overflow detector.
REQ-007 SHALL have port eret  in  1  the ALU-stage instruction is ERET.
REQ-008 SHALL have port reserved_instr  in  1  undefined opcode in the ALU stage; present only under EXC_RESERVED_INSTR_EN.
REQ-009 SHALL have port redirect_ready  in  1  fetch accepts the redirect this cycle.
REQ-010 SHALL have port flush  out  1  kill all younger pipeline instructions.
REQ-011 SHALL have port redirect_valid  out  1  redirect_pc is valid.
REQ-012 SHALL have port redirect_pc  out  32  next fetch address.
REQ-013 SHALL have port epc  out  32  exception PC register.
REQ-014 SHALL have port cause  out  5  ExcCode register.
REQ-015 SHALL have port exl  out  1  exception-level bit.
REQ-016 SHALL have port busy  out  1  high in any state other than IDLE; the pipeline stalls on it.

Function
REQ-017 SHALL implement FSM states IDLE, FLUSH and REDIRECT.
REQ-018 SHALL, in IDLE with instr_valid=1, treat overflow=1 (or reserved_instr=1) as an exception event and ERET=1 with exl=1 as a return event.
REQ-019 SHALL use priority overflow > reserved_instr > eret on simultaneous inputs; only one event is taken.
REQ-020 SHALL on an exception event at edge N load cause (12 = Ov, 10 = RI) and set exl=1, then enter FLUSH.
REQ-021 SHALL on an exception event at edge N also load epc=instr_pc, but only if exl was 0 before the edge.
REQ-022 SHALL on a return event at edge N enter FLUSH with redirect target = epc; exl stays 1 until acceptance.
REQ-023 SHALL drive flush=1 for exactly one cycle in FLUSH (cycle N+1), then enter REDIRECT.
REQ-024 SHALL in REDIRECT hold redirect_valid=1 and a stable redirect_pc (EXC_VECTOR, or latched epc for a return) until a cycle with redirect_ready=1.
REQ-025 SHALL on the accepting edge return to IDLE and, for a return, clear exl; earliest acceptance is cycle N+2.
REQ-026 SHALL ignore overflow, eret and reserved_instr in FLUSH and REDIRECT.
REQ-027 SHALL ignore eret when exl=0 (no event, no flush).
REQ-028 SHALL ignore all inputs when instr_valid=0.
REQ-029 SHALL drive redirect_valid=0 and flush=0 in IDLE, and redirect_pc=0 when redirect_valid=0.
REQ-030 SHALL, when an exception occurs with exl=1, keep epc unchanged, update cause and vector to EXC_VECTOR.

Reset
REQ-031 SHALL on reset asynchronously force state=IDLE, epc=0, cause=0, exl=0, flush=0, redirect_valid=0, redirect_pc=0, busy=0.
REQ-032 SHALL, when reset is asserted mid-operation (FLUSH or REDIRECT), abandon the redirect with no acceptance required.
REQ-033 SHALL leave IDLE no earlier than the first rising edge after reset deassertion.

Configuration
REQ-034 SHALL, with macro EXC_RESERVED_INSTR_EN defined, include the reserved_instr port and the RI exception (cause=10).
REQ-035 SHALL, without EXC_RESERVED_INSTR_EN, omit the reserved_instr port; only overflow and eret are events, and cause is never 10.

Verification
REQ-036 SHALL cover: instr_valid=1, overflow=1, instr_pc=32'h00400010, redirect_ready=1 -> flush=1 at N+1; redirect_valid=1 with redirect_pc=32'h80000180 at N+2; epc=32'h00400010, cause=12, exl=1.
REQ-037 SHALL cover: the above followed by eret=1 at instr_pc=32'h80000190 -> redirect_pc=32'h00400010; exl=0 after acceptance.
REQ-038 SHALL cover: redirect_ready held 0 for 5 cycles in REDIRECT -> redirect_valid and redirect_pc stable for 5 cycles; overflow pulses meanwhile cause no change.
REQ-039 SHALL cover: exl=1 with a second overflow at 32'h80000184 -> epc stays 32'h00400010, vector 32'h80000180.
REQ-040 SHALL cover: eret with exl=0, and overflow with instr_valid=0 -> flush, redirect_valid and busy stay 0.
REQ-041 SHALL cover: reset asserted in REDIRECT -> all outputs 0 immediately, without a clock edge; under EXC_RESERVED_INSTR_EN, reserved_instr=1 -> cause=10.
